// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the streaming UART receiver.
//   uart_parity_e : parity mode encoding (NONE / ODD / EVEN)
//   uart_state_e  : receiver FSM state encoding
//   UART_ERR_W    : width of the per-word error vector, plus bit indices
//   maj3          : 2-of-3 majority vote used by the bit sampler
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } uart_parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    localparam int unsigned UART_ERR_W  = 3;
    localparam int unsigned ERR_FRAME   = 0;
    localparam int unsigned ERR_PARITY  = 1;
    localparam int unsigned ERR_OVERRUN = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: synchronises the RX pin, runs the bit-period counter and
// produces one decision per bit.
//   clk, rst   : clock, synchronous active-high reset
//   rx         : raw asynchronous serial line (idle high)
//   start      : start-edge seen this cycle; counter restarts at bit offset 1
//   run        : receiver is inside a frame; counter free-runs modulo period
//   rx_s       : synchronised line
//   bit_strobe : the bit decision is available this cycle (combinational)
//   bit_val    : decided bit value, valid with bit_strobe (combinational)
// Build option UART_RX_MAJORITY_EN: vote over centre-1/centre/centre+1 and
// strobe at centre+1; otherwise a single sample at the centre.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic start,
    input  logic run,
    output logic rx_s,
    output logic bit_strobe,
    output logic bit_val
);

    localparam int unsigned CNT_W  = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int unsigned CENTRE = CLOCKS_PER_PULSE / 2;

    if (CLOCKS_PER_PULSE < 3) begin : g_cpp_min
        $error("uart_bit_sampler: CLOCKS_PER_PULSE must be >= 3");
    end

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    assign rx_s = sync[1];

    // Two-flop synchroniser, idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    // Bit-period counter: offset 0 is the cycle the start edge is seen on rx_s
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(1);
        end else if (run) begin
            cnt <= (cnt == CNT_W'(CLOCKS_PER_PULSE - 1)) ? '0 : cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    if (CLOCKS_PER_PULSE < 4) begin : g_cpp_maj
        $error("uart_bit_sampler: majority voting needs CLOCKS_PER_PULSE >= 4");
    end

    logic [1:0] hist;

    // hist[0] = rx_s one cycle ago, hist[1] = two cycles ago
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end

    assign bit_strobe = run && (cnt == CNT_W'(CENTRE + 1));
    assign bit_val    = maj3(hist[1], hist[0], rx_s);
`else
    assign bit_strobe = run && (cnt == CNT_W'(CENTRE));
    assign bit_val    = rx_s;
`endif

endmodule

// File: rtl/uart_rx_stream.sv
// uart_rx_stream: UART receiver that packs W_OUT/BITS_PER_WORD frames into
// one W_OUT-bit word and presents it on a valid/ready stream.
//   clk, rst : clock, synchronous active-high reset
//   rx       : asynchronous serial input (idle high)
//   m_data   : assembled word, frame 0 in the low bits
//   m_valid  : m_data/m_error valid
//   m_ready  : consumer accepts on m_valid && m_ready
//   m_error  : {overrun, parity_err, frame_err}, accumulated over one word
// Build option UART_RX_MAJORITY_EN (in uart_bit_sampler) selects 3-sample voting.
module uart_rx_stream
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = 4,
    parameter int unsigned BITS_PER_WORD    = 8,
    parameter int unsigned W_OUT            = 16,
    parameter int unsigned PARITY           = 0,
    parameter int unsigned STOP_BITS        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [W_OUT-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [UART_ERR_W-1:0] m_error
);

    localparam int unsigned N_FRAMES = W_OUT / BITS_PER_WORD;
    localparam int unsigned BIT_W    = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int unsigned FRM_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int unsigned IDX_W    = (W_OUT > 1) ? $clog2(W_OUT) : 1;

    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_START  = 3'(ST_START);
    localparam logic [2:0] S_DATA   = 3'(ST_DATA);
    localparam logic [2:0] S_PARITY = 3'(ST_PARITY);
    localparam logic [2:0] S_STOP   = 3'(ST_STOP);
    localparam logic [2:0] S_BREAK  = 3'(ST_BREAK);

    if ((W_OUT < BITS_PER_WORD) || (W_OUT % BITS_PER_WORD != 0)) begin : g_wout_chk
        $error("uart_rx_stream: W_OUT must be a multiple of BITS_PER_WORD");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_stop_chk
        $error("uart_rx_stream: STOP_BITS must be 1 or 2");
    end
    if (PARITY > 2) begin : g_par_chk
        $error("uart_rx_stream: PARITY must be 0, 1 or 2");
    end

    logic [2:0]            state, state_nxt;
    logic                  rx_s, bit_strobe, bit_val;
    logic                  run_c, start_c;
    logic                  shift_c, par_chk_c, frame_done_c, stop_bad_c;
    logic                  word_done_c, load_ok_c, par_bad_c;
    logic [BIT_W-1:0]      bit_cnt;
    logic [FRM_W-1:0]      frm_cnt;
    logic                  stop_cnt;
    logic                  par_x, par_acc, frm_acc, ovr_pend;
    logic [W_OUT-1:0]      word;
    logic [IDX_W-1:0]      idx_c;
    logic [UART_ERR_W-1:0] err_c;

    uart_bit_sampler #(
        .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .start      (start_c),
        .run        (run_c),
        .rx_s       (rx_s),
        .bit_strobe (bit_strobe),
        .bit_val    (bit_val)
    );

    assign run_c   = (state == S_START) || (state == S_DATA) ||
                     (state == S_PARITY) || (state == S_STOP);
    assign start_c = (state == S_IDLE) && !rx_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_nxt    = state;
        shift_c      = 1'b0;
        par_chk_c    = 1'b0;
        frame_done_c = 1'b0;
        stop_bad_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_c) state_nxt = S_START;
            end
            S_START: begin
                // A high start-bit centre means a glitch: drop it silently
                if (bit_strobe) state_nxt = bit_val ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_strobe) begin
                    shift_c = 1'b1;
                    if (bit_cnt == BIT_W'(BITS_PER_WORD - 1)) begin
                        state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_strobe) begin
                    par_chk_c = 1'b1;
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_strobe) begin
                    if (!bit_val) begin
                        stop_bad_c   = 1'b1;
                        frame_done_c = 1'b1;
                        state_nxt    = S_BREAK;
                    end else if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        frame_done_c = 1'b1;
                        state_nxt    = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Odd mode wants data^parity == 1, even mode wants 0
    assign par_bad_c   = (PARITY == 32'(PAR_ODD)) ? !(par_x ^ bit_val) : (par_x ^ bit_val);
    assign word_done_c = frame_done_c && (frm_cnt == FRM_W'(N_FRAMES - 1));
    assign load_ok_c   = !m_valid || m_ready;
    assign idx_c       = IDX_W'(frm_cnt) * IDX_W'(BITS_PER_WORD) + IDX_W'(bit_cnt);

    // Error vector for the word completing this cycle (last stop bit folded in)
    always_comb begin
        err_c              = '0;
        err_c[ERR_OVERRUN] = ovr_pend;
        err_c[ERR_PARITY]  = par_acc;
        err_c[ERR_FRAME]   = frm_acc | stop_bad_c;
    end

    // Frame assembly, flag accumulation and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            frm_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_x    <= 1'b0;
            par_acc  <= 1'b0;
            frm_acc  <= 1'b0;
            ovr_pend <= 1'b0;
            word     <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_error  <= '0;
        end else begin
            if (start_c) begin
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                par_x    <= 1'b0;
            end
            if (shift_c) begin
                word[idx_c] <= bit_val;
                par_x       <= par_x ^ bit_val;
                bit_cnt     <= bit_cnt + BIT_W'(1);
            end
            if (par_chk_c && par_bad_c) par_acc <= 1'b1;
            if ((state == S_STOP) && bit_strobe && bit_val) stop_cnt <= stop_cnt + 1'b1;
            if (frame_done_c) begin
                frm_cnt <= word_done_c ? '0 : frm_cnt + FRM_W'(1);
            end

            if (word_done_c) begin
                par_acc <= 1'b0;
                frm_acc <= 1'b0;
                if (load_ok_c) begin
                    m_data   <= word;
                    m_error  <= err_c;
                    m_valid  <= 1'b1;
                    ovr_pend <= 1'b0;
                end else begin
                    // Consumer still holds the previous word: drop this one
                    ovr_pend <= 1'b1;
                end
            end else begin
                if (stop_bad_c) frm_acc <= 1'b1;
                if (m_valid && m_ready) m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_stream.sv
// tb_uart_rx_stream: self-checking bench for uart_rx_stream.
// Two instances: default parameters, and PARITY=2 (even) on a separate line.
module tb_uart_rx_stream;

    localparam int CPP = 4;

    logic        clk = 1'b0;
    logic        rst, rx, m_ready, m_valid;
    logic [15:0] m_data;
    logic [2:0]  m_error;
    logic        rx_p, m_ready_p, m_valid_p;
    logic [15:0] m_data_p;
    logic [2:0]  m_error_p;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  e;
    } obs_t;

    obs_t got_q[$];
    obs_t got_p[$];

    logic        hold_prev = 1'b0;
    logic [15:0] prev_d;
    logic [2:0]  prev_e;

    always #5 clk = ~clk;

    uart_rx_stream dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_error (m_error)
    );

    uart_rx_stream #(.PARITY(2)) dut_p (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx_p),
        .m_data  (m_data_p),
        .m_valid (m_valid_p),
        .m_ready (m_ready_p),
        .m_error (m_error_p)
    );

    // Output monitor: collects handshakes and checks hold-while-stalled
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                total++;
                if (m_data !== prev_d || m_error !== prev_e) begin
                    bad++;
                    $display("FAIL hold_stable got data=%h err=%b want data=%h err=%b",
                             m_data, m_error, prev_d, prev_e);
                end
            end
            hold_prev = m_valid && !m_ready;
            prev_d    = m_data;
            prev_e    = m_error;
            if (m_valid && m_ready) begin
                got_q.push_back('{m_data, m_error});
                hs_cnt++;
            end
            if (m_valid_p && m_ready_p) got_p.push_back('{m_data_p, m_error_p});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit pl, input logic v);
        if (pl) rx_p = v;
        else    rx   = v;
    endtask

    task automatic send_bit(input bit pl, input logic v);
        drive(pl, v);
        tick(CPP);
    endtask

    task automatic idle_bits(input bit pl, input int n);
        for (int i = 0; i < n; i++) send_bit(pl, 1'b1);
    endtask

    // One frame: start, 8 data LSB first, optional parity, one stop bit
    task automatic send_frame(input bit pl, input logic [7:0] d, input bit with_par,
                              input logic pbit, input logic stopv);
        send_bit(pl, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(pl, d[i]);
        if (with_par) send_bit(pl, pbit);
        send_bit(pl, stopv);
        if (!stopv) send_bit(pl, 1'b1);
        drive(pl, 1'b1);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    task automatic expect_word(input string name, input bit pl,
                               input logic [15:0] ed, input logic [2:0] ee);
        obs_t o;
        int   waited = 0;
        int   sz;
        sz = pl ? got_p.size() : got_q.size();
        while (sz == 0 && waited < 300) begin
            tick(1);
            waited++;
            sz = pl ? got_p.size() : got_q.size();
        end
        if (sz == 0) begin
            total++;
            bad++;
            $display("FAIL %s no word within 300 cycles, want data=%h err=%b", name, ed, ee);
        end else begin
            if (pl) o = got_p.pop_front();
            else    o = got_q.pop_front();
            cmp({name, "_data"}, 32'(o.d), 32'(ed));
            cmp({name, "_err"},  32'(o.e), 32'(ee));
        end
    endtask

    task automatic expect_none(input string name, input bit pl, input int cycles);
        tick(cycles);
        cmp(name, pl ? got_p.size() : got_q.size(), 0);
    endtask

    typedef struct {
        logic [7:0]  f0;
        logic [7:0]  f1;
        int          gap;
        logic        s0;
        logic        s1;
        logic [15:0] ed;
        logic [2:0]  ee;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [15:0] w;
        logic [7:0]  d0, d1;
        logic        s0, s1, pb0, pb1, wr0, wr1;
        logic [15:0] exp_d;
        logic [2:0]  exp_e;
        int          h0;

        tbl[0] = '{8'h3C, 8'hA5, 0, 1'b1, 1'b1, 16'hA53C, 3'b000};
        tbl[1] = '{8'hFF, 8'h00, 3, 1'b1, 1'b1, 16'h00FF, 3'b000};
        tbl[2] = '{8'h00, 8'hFF, 0, 1'b1, 1'b1, 16'hFF00, 3'b000};
        tbl[3] = '{8'h81, 8'h7E, 1, 1'b1, 1'b1, 16'h7E81, 3'b000};
        tbl[4] = '{8'h55, 8'h66, 2, 1'b0, 1'b1, 16'h6655, 3'b001};
        tbl[5] = '{8'h12, 8'h34, 0, 1'b1, 1'b0, 16'h3412, 3'b001};

        rst = 1'b1; rx = 1'b1; rx_p = 1'b1; m_ready = 1'b1; m_ready_p = 1'b1;
        tick(2);
        rst = 1'b0;

        // Reset and idle
        for (int i = 0; i < 20; i++) begin
            cmp("idle_valid", 32'(m_valid), 0);
            tick(1);
        end
        cmp("idle_err", 32'(m_error), 0);
        cmp("idle_data", 32'(m_data), 0);

        // Directed word table
        for (int i = 0; i < 6; i++) begin
            h0 = hs_cnt;
            send_frame(1'b0, tbl[i].f0, 1'b0, 1'b0, tbl[i].s0);
            idle_bits(1'b0, tbl[i].gap);
            send_frame(1'b0, tbl[i].f1, 1'b0, 1'b0, tbl[i].s1);
            expect_word($sformatf("tbl%0d", i), 1'b0, tbl[i].ed, tbl[i].ee);
            if (i == 0) begin
                tick(30);
                cmp("tbl0_one_pulse", hs_cnt - h0, 1);
            end
            idle_bits(1'b0, 1);
        end

        // Random words, random gaps, occasional bad stop bits
        for (int i = 0; i < 10; i++) begin
            w  = 16'($urandom);
            d0 = w[7:0];
            d1 = w[15:8];
            s0 = ($urandom_range(0, 5) != 0);
            s1 = ($urandom_range(0, 5) != 0);
            exp_d = 16'(int'(d1) * 256 + int'(d0));
            exp_e = (s0 && s1) ? 3'b000 : 3'b001;
            send_frame(1'b0, d0, 1'b0, 1'b0, s0);
            idle_bits(1'b0, $urandom_range(0, 3));
            send_frame(1'b0, d1, 1'b0, 1'b0, s1);
            expect_word($sformatf("rand%0d", i), 1'b0, exp_d, exp_e);
            idle_bits(1'b0, $urandom_range(0, 3));
        end

        // Even parity: wrong parity on frame 0, data still delivered
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        send_frame(1'b1, 8'h12, 1'b1, 1'b0, 1'b1);
        expect_word("par_bad", 1'b1, 16'h1207, 3'b010);

        // Random parity words: error if total ones (data + parity) is odd
        for (int i = 0; i < 6; i++) begin
            d0  = 8'($urandom);
            d1  = 8'($urandom);
            wr0 = ($urandom_range(0, 2) == 0);
            wr1 = ($urandom_range(0, 2) == 0);
            pb0 = 1'(($countones(d0) + int'(wr0)) % 2);
            pb1 = 1'(($countones(d1) + int'(wr1)) % 2);
            exp_d = 16'(int'(d1) * 256 + int'(d0));
            exp_e = ((($countones(d0) + int'(pb0)) % 2 != 0) ||
                     (($countones(d1) + int'(pb1)) % 2 != 0)) ? 3'b010 : 3'b000;
            send_frame(1'b1, d0, 1'b1, pb0, 1'b1);
            idle_bits(1'b1, $urandom_range(0, 2));
            send_frame(1'b1, d1, 1'b1, pb1, 1'b1);
            expect_word($sformatf("par_rand%0d", i), 1'b1, exp_d, exp_e);
        end

        // One-clock low glitch: no frame, no error, next word aligned
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        expect_none("glitch_none", 1'b0, 60);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        expect_word("after_glitch", 1'b0, 16'hC35A, 3'b000);

        // Overrun: second word dropped while the first is held
        m_ready = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        idle_bits(1'b0, 1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        expect_none("ovr_stall", 1'b0, 20);
        cmp("ovr_valid_held", 32'(m_valid), 1);
        cmp("ovr_data_held", 32'(m_data), 32'h1111);
        m_ready = 1'b1;
        expect_word("ovr_first", 1'b0, 16'h1111, 3'b000);
        expect_none("ovr_dropped", 1'b0, 40);
        send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
        expect_word("ovr_flag", 1'b0, 16'h3333, 3'b100);

        // Reset in the middle of frame 0
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        tick(2);
        rst = 1'b0;
        expect_none("rst_mid_none", 1'b0, 80);
        cmp("rst_mid_valid", 32'(m_valid), 0);
        send_frame(1'b0, 8'h9C, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h4E, 1'b0, 1'b0, 1'b1);
        expect_word("rst_mid_next", 1'b0, 16'h4E9C, 3'b000);

        tick(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
